commit_rob: RTL and testbench
=============================

COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 Parameter NUM_ENTRY, default NUM_ENTRY_RB_V (8), table depth; power of two, at least 2.
REQ-002 Parameter NUM_LANE, default NUM_LANES (16), lanes tracked per entry; 1 gives scalar mode.
REQ-003 Parameter WIDTH_NO, default $clog2(NUM_ENTRY), width of the issue number.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 I_Flush  in  1  synchronous clear of all entries and pointers.
REQ-007 I_Issue  in  1  request to allocate one entry.
REQ-008 I_En_Lane  in  NUM_LANE  lanes that must commit the issued instruction.
REQ-009 O_Issue_No  out  WIDTH_NO  slot the next issue takes (tail pointer).
REQ-010 I_Commit  in  NUM_LANE  per-lane commit strobe.
REQ-011 I_Commit_No  in  NUM_LANE x WIDTH_NO  per-lane issue number being committed.
REQ-012 I_Stall  in  1  holds retirement.
REQ-013 O_Retire  out  1  registered one-cycle retire pulse.
REQ-014 O_Retire_No  out  WIDTH_NO  issue number retired with O_Retire.
REQ-015 O_Full, O_Empty  out  1 each  occupancy flags.
REQ-016 O_Count  out  WIDTH_NO+1  number of valid entries.

Function
REQ-017 Each entry holds v, en_lane[NUM_LANE] and en_commit[NUM_LANE]; an entry is complete when v=1 and en_commit equals en_lane.
REQ-018 Issue accepted when I_Issue=1 and O_Full=0: entry at tail gets v=1, en_lane=I_En_Lane, en_commit=0; tail increments modulo NUM_ENTRY.
REQ-019 Issue while O_Full=1 is dropped with no state change; the sender observes O_Full.
REQ-020 A lane commit sets en_commit[l] of entry I_Commit_No[l]; all lanes are processed in parallel in one cycle.
REQ-021 A lane commit to an entry with v=0, or where en_lane[l]=0, is ignored.
REQ-022 Retirement is strictly in order from head, at most one per cycle.
REQ-023 When the head is complete and I_Stall=0: the head entry is cleared, head increments modulo NUM_ENTRY, O_Retire=1 and O_Retire_No=old head on the next cycle.
REQ-024 Latency: a commit strobe that completes the head at edge E produces O_Retire high in the cycle after edge E+1 (two cycles).
REQ-025 An issue with I_En_Lane=0 is complete immediately and retires when it reaches the head.
REQ-026 O_Full=(count==NUM_ENTRY) and O_Empty=(count==0); both are computed from the registered count.
REQ-027 When a retire frees a slot in the same cycle as an issue while full, the issue is still dropped.
REQ-028 Issue and retire in the same cycle leave count unchanged.
REQ-029 A commit targeting the slot being newly issued in the same cycle is ignored, because issue initialises en_commit=0.
REQ-030 I_Flush has priority over issue, commit and retire: on the next edge all v=0, head=tail=0, count=0, O_Retire=0.
REQ-031 O_Retire_No holds its last value while O_Retire=0.

Reset
REQ-032 While reset=0, all entries have v=0, en_lane=0 and en_commit=0; head=tail=count=0.
REQ-033 While reset=0, O_Retire=0, O_Retire_No=0, O_Empty=1, O_Full=0 and O_Issue_No=0.
REQ-034 Reset asserted mid-operation discards all in-flight entries; no retire pulse follows release.

Structure
REQ-035 The entry struct (generalised commit_tab_v with parametrised lane width) shall live in pkg_tpu.
REQ-036 NUM_ENTRY_RB_V, NUM_LANES and issue_no_t shall remain the pkg_tpu defaults for the parameters.
REQ-037 One sub-module, commit_rob_entry, shall hold a single entry's flags and its complete flag; it is instantiated NUM_ENTRY times.
REQ-038 Pointers and count are in the top level; no other hierarchy.

Verification
REQ-039 Reset, then issue 8 entries with I_En_Lane=16'h0003 -> O_Full=1, O_Count=8, O_Issue_No=0; a 9th issue is dropped.
REQ-040 Lanes 0 and 1 commit issue number 2, then number 0, then number 1 -> retires 0, 1, 2 in order on consecutive cycles.
REQ-041 Single lane-0 commit to number 0 with en_lane=16'h0003 -> no retire; a lane-1 commit two cycles later -> O_Retire two cycles after that strobe.
REQ-042 While full, head complete and I_Issue=1 in the same cycle -> retire occurs, issue dropped, O_Count=7.
REQ-043 Tail wraps from 7 to 0 over 20 issue/retire pairs -> O_Retire_No sequence 0..7,0..7,0..3 and no lost entries.
REQ-044 I_Flush with 5 entries pending, and reset=0 asserted mid-stream -> both give O_Empty=1 and no O_Retire afterwards.

Source files
------------

// File: rtl/pkg_tpu.sv
// Shared TPU commit-path types: default table sizes and the reorder-table entry record.
package pkg_tpu;

  localparam int NUM_ENTRY_RB_V = 8;
  localparam int NUM_LANES      = 16;

  typedef logic [$clog2(NUM_ENTRY_RB_V)-1:0] issue_no_t;

  // Lane fields are sized for the widest lane count; narrower tables zero the upper bits.
  typedef struct packed {
    logic                 v;
    logic [NUM_LANES-1:0] en_lane;
    logic [NUM_LANES-1:0] en_commit;
  } commit_tab_v;

endpackage

// File: rtl/commit_rob_if.sv
// Issue / commit / retire bundle of the commit reorder table.
interface commit_rob_if #(
  parameter int NUM_LANE = pkg_tpu::NUM_LANES,
  parameter int WIDTH_NO = $clog2(pkg_tpu::NUM_ENTRY_RB_V)
);
  logic                               I_Flush;
  logic                               I_Issue;
  logic [NUM_LANE-1:0]                I_En_Lane;
  logic [WIDTH_NO-1:0]                O_Issue_No;
  logic [NUM_LANE-1:0]                I_Commit;
  logic [NUM_LANE-1:0][WIDTH_NO-1:0]  I_Commit_No;
  logic                               I_Stall;
  logic                               O_Retire;
  logic [WIDTH_NO-1:0]                O_Retire_No;
  logic                               O_Full;
  logic                               O_Empty;
  logic [WIDTH_NO:0]                  O_Count;

  modport master (
    output I_Flush, I_Issue, I_En_Lane, I_Commit, I_Commit_No, I_Stall,
    input  O_Issue_No, O_Retire, O_Retire_No, O_Full, O_Empty, O_Count
  );

  modport slave (
    input  I_Flush, I_Issue, I_En_Lane, I_Commit, I_Commit_No, I_Stall,
    output O_Issue_No, O_Retire, O_Retire_No, O_Full, O_Empty, O_Count
  );
endinterface

// File: rtl/commit_rob_entry.sv
// One reorder-table slot: tracks which lanes must commit and which have, and flags completion.
module commit_rob_entry import pkg_tpu::*; #(
  parameter int NUM_LANE = NUM_LANES,
  parameter int WIDTH_NO = $clog2(NUM_ENTRY_RB_V),
  parameter int IDX      = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic                              alloc_i,
  input  logic [NUM_LANE-1:0]               en_lane_i,
  input  logic [NUM_LANE-1:0]               commit_i,
  input  logic [NUM_LANE-1:0][WIDTH_NO-1:0] commit_no_i,
  input  logic                              retire_i,
  output logic                              complete_o
);
  localparam logic [WIDTH_NO-1:0] MY_NO = WIDTH_NO'(IDX);

  commit_tab_v         ent_q, ent_d;
  logic [NUM_LANE-1:0] hit;

  always_comb begin
    for (int l = 0; l < NUM_LANE; l++)
      hit[l] = commit_i[l] && (commit_no_i[l] == MY_NO);
  end

  // Allocation wins over a same-cycle commit, so a strobe aimed at a fresh slot is lost.
  always_comb begin
    ent_d = ent_q;
    if (flush_i) begin
      ent_d = '0;
    end else if (alloc_i) begin
      ent_d.v         = 1'b1;
      ent_d.en_lane   = NUM_LANES'(en_lane_i);
      ent_d.en_commit = '0;
    end else if (retire_i) begin
      ent_d = '0;
    end else if (ent_q.v) begin
      ent_d.en_commit = ent_q.en_commit | (NUM_LANES'(hit) & ent_q.en_lane);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign complete_o = ent_q.v && (ent_q.en_commit == ent_q.en_lane);

endmodule

// File: rtl/commit_rob.sv
// In-order commit reorder table: allocate at tail, lanes commit out of order, retire from head.
module commit_rob import pkg_tpu::*; #(
  parameter int NUM_ENTRY = NUM_ENTRY_RB_V,
  parameter int NUM_LANE  = NUM_LANES,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic        clock,
  input  logic        reset,
  commit_rob_if.slave bus
);
  logic [NUM_ENTRY-1:0] complete;
  logic                 full, issue_acc, retire_fire;
  logic [WIDTH_NO-1:0]  head_q, head_d, tail_q, tail_d, retire_no_q, retire_no_d;
  logic [WIDTH_NO:0]    count_q, count_d;
  logic                 retire_q, retire_d;

  assign full        = (count_q == (WIDTH_NO+1)'(NUM_ENTRY));
  assign issue_acc   = bus.I_Issue && !full;
  assign retire_fire = complete[head_q] && !bus.I_Stall;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    retire_d    = 1'b0;
    retire_no_d = retire_no_q;
    if (bus.I_Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue_acc) tail_d = tail_q + 1'b1;
      if (retire_fire) begin
        head_d      = head_q + 1'b1;
        retire_d    = 1'b1;
        retire_no_d = head_q;
      end
      case ({issue_acc, retire_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      retire_q    <= 1'b0;
      retire_no_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      retire_q    <= retire_d;
      retire_no_q <= retire_no_d;
    end
  end

  for (genvar i = 0; i < NUM_ENTRY; i++) begin : g_ent
    commit_rob_entry #(
      .NUM_LANE (NUM_LANE),
      .WIDTH_NO (WIDTH_NO),
      .IDX      (i)
    ) u_ent (
      .clock       (clock),
      .reset       (reset),
      .flush_i     (bus.I_Flush),
      .alloc_i     (issue_acc && (tail_q == WIDTH_NO'(i))),
      .en_lane_i   (bus.I_En_Lane),
      .commit_i    (bus.I_Commit),
      .commit_no_i (bus.I_Commit_No),
      .retire_i    (retire_fire && (head_q == WIDTH_NO'(i))),
      .complete_o  (complete[i])
    );
  end

  assign bus.O_Issue_No  = tail_q;
  assign bus.O_Retire    = retire_q;
  assign bus.O_Retire_No = retire_no_q;
  assign bus.O_Full      = full;
  assign bus.O_Empty     = (count_q == '0);
  assign bus.O_Count     = count_q;

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: fill, out-of-order commit, partial commit, wrap, stall, flush, reset.
module tb_commit_rob;
  import pkg_tpu::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  commit_rob_if #(.NUM_LANE(16), .WIDTH_NO(3)) bus ();

  commit_rob #(.NUM_ENTRY(8), .NUM_LANE(16), .WIDTH_NO(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.I_Flush     = 1'b0;
    bus.I_Issue     = 1'b0;
    bus.I_En_Lane   = '0;
    bus.I_Commit    = '0;
    bus.I_Commit_No = '0;
    bus.I_Stall     = 1'b0;
  endtask

  task automatic commit2(input issue_no_t no);
    bus.I_Commit       = 16'h0003;
    bus.I_Commit_No[0] = no;
    bus.I_Commit_No[1] = no;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    total++; if (bus.O_Empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.O_Empty); else passed++;
    total++; if (bus.O_Full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.O_Full); else passed++;
    total++; if (bus.O_Count !== 4'd0) $display("FAIL reset_count got %0d want 0", bus.O_Count); else passed++;
    total++; if (bus.O_Issue_No !== 3'd0) $display("FAIL reset_issue_no got %0d want 0", bus.O_Issue_No); else passed++;
    total++; if (bus.O_Retire !== 1'b0 || bus.O_Retire_No !== 3'd0)
      $display("FAIL reset_retire got %b/%0d want 0/0", bus.O_Retire, bus.O_Retire_No); else passed++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    bus.I_Issue   = 1'b1;
    bus.I_En_Lane = 16'h0003;
    repeat (8) tick();
    total++; if (bus.O_Full !== 1'b1) $display("FAIL fill_full got %b want 1", bus.O_Full); else passed++;
    total++; if (bus.O_Count !== 4'd8) $display("FAIL fill_count got %0d want 8", bus.O_Count); else passed++;
    total++; if (bus.O_Issue_No !== 3'd0) $display("FAIL fill_issue_no got %0d want 0", bus.O_Issue_No); else passed++;
    tick();
    total++; if (bus.O_Count !== 4'd8 || bus.O_Issue_No !== 3'd0)
      $display("FAIL fill_drop got count %0d tail %0d want 8 0", bus.O_Count, bus.O_Issue_No); else passed++;
    idle_inputs();
  endtask

  task automatic test_out_of_order();
    commit2(3'd2); tick();
    total++; if (bus.O_Retire !== 1'b0) $display("FAIL ooo_early1 got %b want 0", bus.O_Retire); else passed++;
    commit2(3'd0); tick();
    total++; if (bus.O_Retire !== 1'b0) $display("FAIL ooo_early2 got %b want 0", bus.O_Retire); else passed++;
    commit2(3'd1); tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.O_Retire !== 1'b1 || bus.O_Retire_No !== 3'(k))
        $display("FAIL ooo_retire%0d got %b/%0d want 1/%0d", k, bus.O_Retire, bus.O_Retire_No, k); else passed++;
      tick();
    end
    total++; if (bus.O_Retire !== 1'b0 || bus.O_Count !== 4'd5)
      $display("FAIL ooo_after got %b/%0d want 0/5", bus.O_Retire, bus.O_Count); else passed++;
    total++; if (bus.O_Retire_No !== 3'd2) $display("FAIL ooo_hold got %0d want 2", bus.O_Retire_No); else passed++;
  endtask

  task automatic test_partial_commit();
    bus.I_Commit = 16'h0001; bus.I_Commit_No[0] = 3'd3; tick();
    idle_inputs();
    tick();
    total++; if (bus.O_Retire !== 1'b0) $display("FAIL partial_noretire got %b want 0", bus.O_Retire); else passed++;
    bus.I_Commit = 16'h0002; bus.I_Commit_No[1] = 3'd3; tick();
    idle_inputs();
    total++; if (bus.O_Retire !== 1'b0) $display("FAIL partial_lat1 got %b want 0", bus.O_Retire); else passed++;
    tick();
    total++; if (bus.O_Retire !== 1'b1 || bus.O_Retire_No !== 3'd3)
      $display("FAIL partial_retire got %b/%0d want 1/3", bus.O_Retire, bus.O_Retire_No); else passed++;
    tick();
    total++; if (bus.O_Retire !== 1'b0 || bus.O_Count !== 4'd4)
      $display("FAIL partial_after got %b/%0d want 0/4", bus.O_Retire, bus.O_Count); else passed++;
  endtask

  task automatic test_full_retire();
    bus.I_Issue = 1'b1; bus.I_En_Lane = 16'h0003;
    repeat (4) tick();
    idle_inputs();
    total++; if (bus.O_Full !== 1'b1) $display("FAIL fr_full got %b want 1", bus.O_Full); else passed++;
    commit2(3'd4); tick();
    idle_inputs();
    bus.I_Issue = 1'b1; bus.I_En_Lane = 16'h0003; tick();
    idle_inputs();
    total++; if (bus.O_Retire !== 1'b1 || bus.O_Retire_No !== 3'd4)
      $display("FAIL fr_retire got %b/%0d want 1/4", bus.O_Retire, bus.O_Retire_No); else passed++;
    total++; if (bus.O_Count !== 4'd7 || bus.O_Issue_No !== 3'd4)
      $display("FAIL fr_drop got count %0d tail %0d want 7 4", bus.O_Count, bus.O_Issue_No); else passed++;
  endtask

  task automatic test_flush();
    commit2(3'd5); tick();
    commit2(3'd6); tick();
    idle_inputs();
    tick(); tick();
    total++; if (bus.O_Count !== 4'd5) $display("FAIL flush_pending got %0d want 5", bus.O_Count); else passed++;
    commit2(3'd7); tick();
    bus.I_Flush = 1'b1; bus.I_Issue = 1'b1; bus.I_En_Lane = 16'h0003; tick();
    idle_inputs();
    total++; if (bus.O_Empty !== 1'b1 || bus.O_Count !== 4'd0 || bus.O_Issue_No !== 3'd0)
      $display("FAIL flush_clear got empty %b count %0d tail %0d want 1 0 0", bus.O_Empty, bus.O_Count, bus.O_Issue_No); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.O_Retire !== 1'b0) $display("FAIL flush_noretire%0d got %b want 0", k, bus.O_Retire); else passed++;
      tick();
    end
  endtask

  task automatic test_wrap();
    bus.I_Issue = 1'b1; bus.I_En_Lane = '0;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (k == 19) bus.I_Issue = 1'b0;
      tick();
      total++; if (bus.O_Retire !== 1'b1 || bus.O_Retire_No !== 3'(k % 8))
        $display("FAIL wrap_retire%0d got %b/%0d want 1/%0d", k, bus.O_Retire, bus.O_Retire_No, k % 8); else passed++;
      if (k == 10) begin
        total++; if (bus.O_Count !== 4'd1) $display("FAIL wrap_count got %0d want 1", bus.O_Count); else passed++;
      end
    end
    tick();
    total++; if (bus.O_Retire !== 1'b0 || bus.O_Empty !== 1'b1 || bus.O_Issue_No !== 3'd4)
      $display("FAIL wrap_end got %b empty %b tail %0d want 0 1 4", bus.O_Retire, bus.O_Empty, bus.O_Issue_No); else passed++;
    idle_inputs();
  endtask

  task automatic test_stall();
    bus.I_Stall = 1'b1; bus.I_Issue = 1'b1; bus.I_En_Lane = '0; tick();
    bus.I_Issue = 1'b0;
    tick(); tick();
    total++; if (bus.O_Retire !== 1'b0 || bus.O_Count !== 4'd1)
      $display("FAIL stall_hold got %b/%0d want 0/1", bus.O_Retire, bus.O_Count); else passed++;
    bus.I_Stall = 1'b0; tick();
    total++; if (bus.O_Retire !== 1'b1 || bus.O_Retire_No !== 3'd4)
      $display("FAIL stall_release got %b/%0d want 1/4", bus.O_Retire, bus.O_Retire_No); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.I_Issue = 1'b1; bus.I_En_Lane = 16'h0003;
    repeat (3) tick();
    idle_inputs();
    commit2(3'd5); tick();
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    total++; if (bus.O_Empty !== 1'b1 || bus.O_Count !== 4'd0 || bus.O_Issue_No !== 3'd0)
      $display("FAIL rst_mid got empty %b count %0d tail %0d want 1 0 0", bus.O_Empty, bus.O_Count, bus.O_Issue_No); else passed++;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (bus.O_Retire !== 1'b0) $display("FAIL rst_noretire%0d got %b want 0", k, bus.O_Retire); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_out_of_order();
    test_partial_commit();
    test_full_retire();
    test_flush();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
